// File: rtl/leaf_arb_pkg.sv
// Shared types, default sizes and helpers for the leaf stream round-robin arbiter.
package leaf_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned DEF_PAYLOAD_BITS = 32;
  localparam int unsigned DEF_NUM_REQ      = 4;
  localparam int unsigned DEF_BURST_LEN    = 16;

  // Ceiling log2 for elaboration-time width derivation.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = 32'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request searching upward from ptr+1.
module rr_pick
  import leaf_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
  parameter int unsigned IDX_BITS = clog2(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [IDX_BITS-1:0] ptr,
  output logic                any,
  output logic [IDX_BITS-1:0] idx
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [2*NUM_REQ-1:0] w_shift;
  logic [NUM_REQ-1:0]   w_rot;
  logic                 w_found;
  int unsigned          w_k;
  int unsigned          w_sum;

  // Bit k of w_rot is request (ptr+1+k) mod NUM_REQ.
  assign w_dbl   = {req, req};
  assign w_shift = w_dbl >> (int'(ptr) + 1);
  assign w_rot   = w_shift[NUM_REQ-1:0];

  always_comb begin
    w_found = 1'b0;
    w_k     = 0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_k     = 32'(k);
      end
    end
    w_sum = 32'(ptr) + 32'd1 + w_k;
    if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
  end

  assign any = w_found;
  assign idx = IDX_BITS'(w_sum);

endmodule

// File: rtl/leaf_stream_rr_arbiter.sv
// Shares one registered valid/ack output stream between NUM_REQ sources,
// granting round-robin bursts of up to BURST_LEN beats tagged with the source index.
module leaf_stream_rr_arbiter
  import leaf_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
  parameter int unsigned PAYLOAD_BITS = DEF_PAYLOAD_BITS,
  parameter int unsigned IDX_BITS     = clog2(DEF_NUM_REQ),
  parameter int unsigned BURST_LEN    = DEF_BURST_LEN,
  parameter int unsigned CNT_BITS     = 5
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst_n,
  input  logic [NUM_REQ-1:0]              req_en,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] in_tdata,
  input  logic [NUM_REQ-1:0]              in_tvalid,
  output logic [NUM_REQ-1:0]              in_tready,
  output logic [PAYLOAD_BITS-1:0]         out_tdata,
  output logic                            out_tvalid,
  input  logic                            out_tready,
  output logic [IDX_BITS-1:0]             out_tdest,
  output logic                            grant_vld,
  output logic [IDX_BITS-1:0]             grant_idx
);

  arb_state_e             r_state;
  logic [IDX_BITS-1:0]    r_rr_ptr;
  logic [IDX_BITS-1:0]    r_grant_idx;
  logic [CNT_BITS-1:0]    r_cnt;
  logic                   r_out_tvalid;
  logic [PAYLOAD_BITS-1:0] r_out_tdata;
  logic [IDX_BITS-1:0]    r_out_tdest;

  logic [NUM_REQ-1:0]     w_elig;
  logic                   w_any;
  logic [IDX_BITS-1:0]    w_pick;
  logic                   w_slot_free;
  logic                   w_gnt_valid;
  logic                   w_accept;
  logic                   w_last;
  logic                   w_release;
  logic [NUM_REQ-1:0]     w_ready;
  logic [PAYLOAD_BITS-1:0] w_gnt_data;

  assign w_elig      = in_tvalid & req_en;
  assign w_slot_free = !r_out_tvalid || out_tready;
  assign w_gnt_valid = in_tvalid[r_grant_idx];
  assign w_gnt_data  = in_tdata[int'(r_grant_idx)*PAYLOAD_BITS +: PAYLOAD_BITS];
  assign w_accept    = (r_state == GRANT) && w_gnt_valid && w_slot_free;
  assign w_last      = w_accept && (r_cnt == CNT_BITS'(BURST_LEN - 1));
  // Release is never taken under backpressure: both paths require a free slot.
  assign w_release   = (r_state == GRANT) && (w_last || (w_slot_free && !w_gnt_valid));

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .IDX_BITS (IDX_BITS)
  ) u_pick (
    .req (w_elig),
    .ptr (r_rr_ptr),
    .any (w_any),
    .idx (w_pick)
  );

  // Only the granted source sees ready, and only when the out stage can take a beat.
  always_comb begin
    w_ready = '0;
    if (r_state == GRANT) w_ready[r_grant_idx] = w_slot_free;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state      <= IDLE;
      r_rr_ptr     <= IDX_BITS'(NUM_REQ - 1);
      r_grant_idx  <= '0;
      r_cnt        <= '0;
      r_out_tvalid <= 1'b0;
      r_out_tdata  <= '0;
      r_out_tdest  <= '0;
    end else begin
      if (w_accept) begin
        r_out_tvalid <= 1'b1;
        r_out_tdata  <= w_gnt_data;
        r_out_tdest  <= r_grant_idx;
      end else if (out_tready) begin
        r_out_tvalid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant_idx <= w_pick;
            r_cnt       <= '0;
            r_state     <= GRANT;
          end
        end
        GRANT: begin
          if (w_accept) r_cnt <= r_cnt + CNT_BITS'(1);
          if (w_release) begin
            r_rr_ptr <= r_grant_idx;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_tready  = w_ready;
  assign out_tdata  = r_out_tdata;
  assign out_tvalid = r_out_tvalid;
  assign out_tdest  = r_out_tdest;
  assign grant_vld  = (r_state == GRANT);
  assign grant_idx  = r_grant_idx;

endmodule

// File: tb/tb_leaf_stream_rr_arbiter.sv
// Randomized scoreboard bench for leaf_stream_rr_arbiter against a cycle-level reference model.
module tb_leaf_stream_rr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned PB = 32;
  localparam int unsigned IB = 2;
  localparam int unsigned BL = 4;
  localparam int unsigned CB = 3;

  logic              ap_clk = 1'b0;
  logic              ap_rst_n;
  logic [N-1:0]      req_en;
  logic [N*PB-1:0]   in_tdata;
  logic [N-1:0]      in_tvalid;
  logic [N-1:0]      in_tready;
  logic [PB-1:0]     out_tdata;
  logic              out_tvalid;
  logic              out_tready;
  logic [IB-1:0]     out_tdest;
  logic              grant_vld;
  logic [IB-1:0]     grant_idx;

  always #5 ap_clk = ~ap_clk;

  leaf_stream_rr_arbiter #(
    .NUM_REQ(N), .PAYLOAD_BITS(PB), .IDX_BITS(IB), .BURST_LEN(BL), .CNT_BITS(CB)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .req_en(req_en), .in_tdata(in_tdata),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .out_tdata(out_tdata),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdest(out_tdest),
    .grant_vld(grant_vld), .grant_idx(grant_idx)
  );

  typedef struct packed {
    logic [PB-1:0] data;
    logic [IB-1:0] dest;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model: arbitration expressed as integer bookkeeping.
  bit m_busy;
  int m_g;
  int m_ptr;
  int m_cnt;
  bit m_ovalid;
  int seq[N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PB-1:0] word_of(input int i);
    return {8'(i + 1), 24'(seq[i])};
  endfunction

  task automatic model_reset();
    m_busy   = 1'b0;
    m_g      = 0;
    m_ptr    = N - 1;
    m_cnt    = 0;
    m_ovalid = 1'b0;
    exp_q.delete();
  endtask

  task automatic drive(input logic [N-1:0] en, input logic [N-1:0] v, input logic rdy);
    req_en     = en;
    in_tvalid  = v;
    out_tready = rdy;
    for (int i = 0; i < int'(N); i++) in_tdata[i*PB +: PB] = word_of(i);
  endtask

  task automatic model_cycle();
    logic [N-1:0] exp_rdy;
    bit sf;
    bit acc;
    exp_rdy = '0;
    acc     = 1'b0;
    sf      = !m_ovalid || out_tready;
    if (m_busy && sf) exp_rdy[m_g] = 1'b1;
    check("in_tready", 64'(in_tready), 64'(exp_rdy));
    if (!m_busy) begin
      for (int k = 1; k <= int'(N); k++) begin
        int j;
        j = (m_ptr + k) % int'(N);
        if (in_tvalid[j] && req_en[j]) begin
          m_busy = 1'b1;
          m_g    = j;
          m_cnt  = 0;
          break;
        end
      end
    end else begin
      acc = in_tvalid[m_g] && sf;
      if (acc) begin
        exp_q.push_back('{data: word_of(m_g), dest: IB'(m_g)});
        seq[m_g]++;
        m_cnt++;
      end
      if ((acc && m_cnt == int'(BL)) || (sf && !in_tvalid[m_g])) begin
        m_busy = 1'b0;
        m_ptr  = m_g;
      end
    end
    if (acc) m_ovalid = 1'b1;
    else if (out_tready) m_ovalid = 1'b0;
  endtask

  task automatic cycle(input logic [N-1:0] en, input logic [N-1:0] v, input logic rdy);
    @(posedge ap_clk);
    #2;
    drive(en, v, rdy);
    #1;
    check("out_tvalid", 64'(out_tvalid), 64'(m_ovalid));
    check("grant_vld", 64'(grant_vld), 64'(m_busy));
    check("grant_idx", 64'(grant_idx), 64'(m_g));
    model_cycle();
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_out_tvalid"}, 64'(out_tvalid), 64'd0);
    check({tag, "_out_tdata"}, 64'(out_tdata), 64'd0);
    check({tag, "_out_tdest"}, 64'(out_tdest), 64'd0);
    check({tag, "_in_tready"}, 64'(in_tready), 64'd0);
    check({tag, "_grant_vld"}, 64'(grant_vld), 64'd0);
    check({tag, "_grant_idx"}, 64'(grant_idx), 64'd0);
  endtask

  task automatic run_phase(input int n, input logic [N-1:0] en, input int vp, input int rp,
                           input bit rand_en);
    for (int c = 0; c < n; c++) begin
      logic [N-1:0] v;
      logic [N-1:0] e;
      for (int i = 0; i < int'(N); i++) v[i] = ($urandom_range(99) < 32'(vp));
      e = rand_en ? N'($urandom) : en;
      cycle(e, v, $urandom_range(99) < 32'(rp));
    end
  endtask

  // Asynchronous reset between clock edges, with inputs idled so nothing is granted at release.
  task automatic mid_reset();
    @(posedge ap_clk);
    #4;
    ap_rst_n = 1'b0;
    #1;
    check_cleared("midrst");
    drive('1, '0, 1'b1);
    model_reset();
    repeat (2) @(posedge ap_clk);
    #4;
    ap_rst_n = 1'b1;
  endtask

  // Monitor: pops expected beats on each transfer and checks hold-stability under backpressure.
  initial begin
    bit            hold;
    logic [PB-1:0] h_data;
    logic [IB-1:0] h_dest;
    beat_t         e;
    hold = 1'b0;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("hold_tdata", 64'(out_tdata), 64'(h_data));
          check("hold_tdest", 64'(out_tdest), 64'(h_dest));
        end
        hold   = out_tvalid && !out_tready;
        h_data = out_tdata;
        h_dest = out_tdest;
        if (out_tvalid && out_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected actual dest=%0d data=%0h required no beat", out_tdest, out_tdata);
          end else begin
            e = exp_q.pop_front();
            check("sb_tdata", 64'(out_tdata), 64'(e.data));
            check("sb_tdest", 64'(out_tdest), 64'(e.dest));
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < int'(N); i++) seq[i] = 0;
    ap_rst_n = 1'b0;
    drive('1, '1, 1'b1);
    repeat (3) @(posedge ap_clk);
    #1;
    check_cleared("reset");
    drive('1, '0, 1'b1);
    model_reset();
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    run_phase(40, 4'b1111, 100, 100, 1'b0);          // fairness, continuous traffic
    run_phase(30, 4'b1010, 100, 100, 1'b0);          // masked requesters
    repeat (3) cycle(4'b1111, 4'b0000, 1'b1);        // drain to IDLE
    repeat (4) cycle(4'b1111, 4'b0100, 1'b1);        // early release of requester 2
    repeat (6) cycle(4'b1111, 4'b1000, 1'b1);
    repeat (3) cycle(4'b1111, 4'b1111, 1'b1);        // backpressure mid-burst
    repeat (5) cycle(4'b1111, 4'b1111, 1'b0);
    repeat (10) cycle(4'b1111, 4'b1111, 1'b1);
    run_phase(60, 4'b1111, 60, 70, 1'b0);
    run_phase(6, 4'b1111, 100, 100, 1'b0);
    mid_reset();
    run_phase(20, 4'b1111, 100, 100, 1'b0);
    run_phase(300, 4'b1111, 50, 50, 1'b1);
    repeat (10) cycle(4'b1111, 4'b0000, 1'b1);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/leaf_stream_rr_arbiter.md
Name: leaf_stream_rr_arbiter

Overview:
Round-robin scheduler that shares one leaf_interface user output port (32-bit valid/ack stream toward the BFT) between NUM_REQ operator output streams.
- Grants one requester at a time for a burst of at most BURST_LEN beats.
- Tags each beat with the source index on out_tdest.
- Drives the shared port through a single registered output stage.
- Sits between the HLS operator Output_*_V streams and leaf_interface din_leaf_user2interface / vld_user2interface / ack_interface2user.

Parameters:
- NUM_REQ, 4, number of requesting streams (2..16)
- PAYLOAD_BITS, 32, stream data width
- IDX_BITS, 2, width of requester index; must equal clog2(NUM_REQ)
- BURST_LEN, 16, maximum beats per grant (>=1)
- CNT_BITS, 5, burst counter width; must satisfy 2^CNT_BITS > BURST_LEN

Ports:
- ap_clk, input, 1, clock
- ap_rst_n, input, 1, asynchronous active-low reset
- req_en, input, NUM_REQ, per-requester enable mask; sampled only in IDLE
- in_tdata, input, NUM_REQ*PAYLOAD_BITS, requester data; requester i occupies bits [i*PAYLOAD_BITS +: PAYLOAD_BITS]
- in_tvalid, input, NUM_REQ, requester valid
- in_tready, output, NUM_REQ, requester ready
- out_tdata, output, PAYLOAD_BITS, shared stream data to leaf_interface
- out_tvalid, output, 1, shared stream valid
- out_tready, input, 1, shared stream ack from leaf_interface
- out_tdest, output, IDX_BITS, source index of the current out beat
- grant_vld, output, 1, high while in GRANT
- grant_idx, output, IDX_BITS, currently or last granted index

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, rr_ptr=NUM_REQ-1, so requester 0 has first priority
  - cnt=0
  - out_tvalid=0, out_tdata=0, out_tdest=0
  - grant_vld=0, grant_idx=0
  - in_tready=0
- Handshake: a beat transfers on valid&ready. out_tdata and out_tdest hold stable while out_tvalid=1 and out_tready=0.
- slot_free = !out_tvalid | out_tready.
- IDLE:
  - elig = in_tvalid & req_en.
  - If elig!=0, pick the first set bit searching upward from rr_ptr+1 (mod NUM_REQ). Register the winner into grant_idx and go to GRANT; cnt=0.
  - In IDLE, in_tready is all-zero.
- GRANT (g=grant_idx):
  - in_tready[g] = slot_free; all other bits 0 (combinational from state, g and out stage).
  - On accept (in_tvalid[g] & in_tready[g]): load out_tdata and out_tdest=g, set out_tvalid, cnt++.
  - If out_tready and no accept in the same cycle, clear out_tvalid.
  - Go to IDLE and set rr_ptr=g at the end of the cycle in which either:
    - the accept makes cnt reach BURST_LEN, or
    - slot_free=1 and in_tvalid[g]=0 (requester went idle).
  - No release while slot_free=0; the grant is held under backpressure.
- Latency:
  - First in_tvalid in IDLE -> grant registered next cycle -> beat accepted that cycle if slot free -> out_tvalid the cycle after. First beat therefore appears 2 cycles after the request.
  - Steady-state throughput is 1 beat/cycle within a burst.
  - Re-arbitration costs 1 idle input cycle; the out stage may still drain during it.
- Boundaries:
  - BURST_LEN=1 gives one beat per grant with strict alternation.
  - Single active requester is re-granted after each 1-cycle IDLE gap.
  - req_en deasserted mid-burst does not cut the burst; it is honoured at the next arbitration.
  - Pointer wrap: with rr_ptr=NUM_REQ-1, the search starts at index 0.
  - Reset mid-burst drops the out-stage beat and the grant, with no partial state kept.
- grant_vld = (state==GRANT).

Decomposition:
- Package leaf_arb_pkg holds:
  - state enum {IDLE, GRANT}
  - default constants PAYLOAD_BITS=32, NUM_REQ=4, BURST_LEN=16
  - a clog2 function
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: req[NUM_REQ], ptr[IDX_BITS].
  - Outputs: any, idx[IDX_BITS].
  - Implemented as a double-width rotate plus priority encoder.

Test Plan:
- Reset check: hold ap_rst_n=0 with all in_tvalid=1 -> out_tvalid=0, in_tready=0, grant_idx=0. After release, the first grant goes to requester 0 and its first beat appears on out_tdata 2 cycles later with out_tdest=0.
- Round-robin fairness: 4 requesters continuously valid, BURST_LEN=4, out_tready=1 -> out_tdest sequence is 0×4, 1×4, 2×4, 3×4, 0×4, with exactly 1 bubble cycle between bursts.
- Early release: requester 2 sends 3 beats (0xA0..0xA2) then drops valid -> grant released after beat 3, requester 3 is granted next, cnt restarts at 0.
- Backpressure: out_tready=0 for 5 cycles mid-burst -> out_tdata frozen, in_tready[g]=0, no beat lost or duplicated. After release, data order is preserved.
- Mask: req_en=4'b1010 with all valid -> only indices 1 and 3 are granted, alternating.
- Async reset mid-burst: assert ap_rst_n=0 asynchronously between clock edges during a burst -> outputs clear immediately. After release, arbitration restarts from requester 0.
